// File: rtl/cci_mpf_prim_rob_rd_issue_pkg.sv
// Shared types and ROB meta packing helpers for the read-ROB issue front end.
package cci_mpf_prim_rob_rd_issue_pkg;

  typedef logic [1:0] t_line_idx;

  typedef enum logic [0:0] {
    ISSUE_IDLE = 1'b0,
    ISSUE_BUSY = 1'b1
  } t_issue_state;

  // Meta is carried at a fixed maximum width; callers size-cast down to their own width.
  localparam int META_MAX_BITS = 64;

  typedef logic [META_MAX_BITS-1:0] t_meta_max;
  typedef logic [META_MAX_BITS+2:0] t_rob_meta_max;

  typedef struct packed {
    t_meta_max meta;
    t_line_idx line_idx;
    logic      eop;
  } t_rob_meta_fields;

  function automatic t_rob_meta_max pack_rob_meta(input t_meta_max meta,
                                                  input t_line_idx line_idx,
                                                  input logic      eop);
    return {meta, line_idx, eop};
  endfunction

  function automatic t_rob_meta_fields unpack_rob_meta(input t_rob_meta_max rob_meta);
    t_rob_meta_fields f;
    f.meta     = rob_meta[META_MAX_BITS+2:3];
    f.line_idx = rob_meta[2:1];
    f.eop      = rob_meta[0];
    return f;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_rob_rd_issue_chk.sv
// Protocol checks on the client, ROB and memory interfaces of the issue block.
module cci_mpf_prim_rob_rd_issue_chk #(
  parameter int N_ROB_ENTRIES = 32,
  parameter int MAX_LINES     = 4,
  parameter int TAG           = 5
) (
  input logic         clk,
  input logic         reset,
  input logic         req_en,
  input logic         req_rdy,
  input logic [1:0]   req_nlines,
  input logic         rob_enq_en,
  input logic         mem_req_valid,
  input logic         rob_not_full,
  input logic         rob_data_en,
  input logic [TAG:0] outstanding
);

  a_req_when_rdy: assert property (@(posedge clk) disable iff (reset)
    req_en |-> req_rdy) else $error("req_en while req_rdy=0");

  a_nlines_legal: assert property (@(posedge clk) disable iff (reset)
    req_en |-> (32'(req_nlines) < MAX_LINES)) else $error("req_nlines out of range");

  a_no_issue_full: assert property (@(posedge clk) disable iff (reset)
    rob_enq_en |-> rob_not_full) else $error("issue while ROB full");

  a_enq_eq_mem: assert property (@(posedge clk) disable iff (reset)
    rob_enq_en == mem_req_valid) else $error("rob_enq_en differs from mem_req_valid");

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (rob_data_en && !rob_enq_en) |-> (outstanding != {(TAG+1){1'b0}}))
    else $error("outstanding decrement at zero");

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    32'(outstanding) <= N_ROB_ENTRIES) else $error("outstanding above ROB depth");

endmodule

// File: rtl/cci_mpf_prim_rob_rd_issue_rsp_reg.sv
// Registered memory response stage feeding the ROB data port, plus the
// count of lines issued but not yet written back.
module cci_mpf_prim_rob_rd_issue_rsp_reg #(
  parameter int TAG         = 5,
  parameter int N_DATA_BITS = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue,
  input  logic                   mem_rsp_valid,
  input  logic [TAG-1:0]         mem_rsp_tag,
  input  logic [N_DATA_BITS-1:0] mem_rsp_data,
  output logic                   rob_data_en,
  output logic [TAG-1:0]         rob_data_idx,
  output logic [N_DATA_BITS-1:0] rob_data,
  output logic [TAG:0]           outstanding
);

  localparam logic [TAG:0] CNT_ONE = {{TAG{1'b0}}, 1'b1};

  // One-cycle response register; memory has no backpressure so every beat lands
  always_ff @(posedge clk) begin
    if (reset) begin
      rob_data_en  <= 1'b0;
      rob_data_idx <= {TAG{1'b0}};
      rob_data     <= {N_DATA_BITS{1'b0}};
    end else begin
      rob_data_en  <= mem_rsp_valid;
      rob_data_idx <= mem_rsp_tag;
      rob_data     <= mem_rsp_data;
    end
  end

  // Lines in flight: issue adds one, a registered write-back removes one
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= {(TAG+1){1'b0}};
    end else begin
      case ({issue, rob_data_en})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: rtl/cci_mpf_prim_rob_rd_issue.sv
// Splits multi-line client reads into per-line memory requests tagged by ROB index.
// Optional counters are enabled with CCI_MPF_PRIM_ROB_RD_ISSUE_STATS_EN.
module cci_mpf_prim_rob_rd_issue
  import cci_mpf_prim_rob_rd_issue_pkg::*;
#(
  parameter int N_ROB_ENTRIES      = 32,
  parameter int N_ADDR_BITS        = 42,
  parameter int N_DATA_BITS        = 512,
  parameter int N_CLIENT_META_BITS = 8,
  parameter int MAX_LINES          = 4,
  parameter int TAG                = $clog2(N_ROB_ENTRIES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_en,
  input  logic [N_ADDR_BITS-1:0]        req_addr,
  input  logic [1:0]                    req_nlines,
  input  logic [N_CLIENT_META_BITS-1:0] req_meta,
  output logic                          req_rdy,
  output logic                          rob_enq_en,
  output logic [N_CLIENT_META_BITS+2:0] rob_enq_meta,
  input  logic                          rob_not_full,
  input  logic [TAG-1:0]                rob_enq_idx,
  output logic                          mem_req_valid,
  output logic [N_ADDR_BITS-1:0]        mem_req_addr,
  output logic [TAG-1:0]                mem_req_tag,
  input  logic                          mem_req_almost_full,
  input  logic                          mem_rsp_valid,
  input  logic [TAG-1:0]                mem_rsp_tag,
  input  logic [N_DATA_BITS-1:0]        mem_rsp_data,
  output logic                          rob_data_en,
  output logic [TAG-1:0]                rob_data_idx,
  output logic [N_DATA_BITS-1:0]        rob_data,
`ifdef CCI_MPF_PRIM_ROB_RD_ISSUE_STATS_EN
  output logic [31:0]                   stat_lines,
  output logic [31:0]                   stat_stall_cycles,
`endif
  output logic [TAG:0]                  outstanding
);

  t_issue_state                  state_r;
  logic                          armed_r;
  logic [N_ADDR_BITS-1:0]        base_r;
  logic [N_CLIENT_META_BITS-1:0] meta_r;
  t_line_idx                     line_idx_r;
  t_line_idx                     remaining_r;

  logic issue_ok_s;
  logic issue_s;
  logic eop_s;
  logic accept_s;

  // Issue decision; armed_r holds off issue during the capture cycle
  always_comb begin
    issue_ok_s = rob_not_full && !mem_req_almost_full;
    issue_s    = (state_r == ISSUE_BUSY) && armed_r && issue_ok_s;
    eop_s      = (remaining_r == 2'd0);
    if (state_r == ISSUE_IDLE) begin
      req_rdy = 1'b1;
    end else begin
      req_rdy = issue_s && eop_s;
    end
    accept_s = req_en && req_rdy;
  end

  assign rob_enq_en    = issue_s;
  assign mem_req_valid = issue_s;
  assign mem_req_tag   = rob_enq_idx;
  assign mem_req_addr  = base_r + N_ADDR_BITS'(line_idx_r);
  assign rob_enq_meta  = (N_CLIENT_META_BITS+3)'(
                           pack_rob_meta(t_meta_max'(meta_r), line_idx_r, eop_s));

  // Request capture and per-line walk
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ISSUE_IDLE;
      armed_r     <= 1'b0;
      base_r      <= {N_ADDR_BITS{1'b0}};
      meta_r      <= {N_CLIENT_META_BITS{1'b0}};
      line_idx_r  <= 2'd0;
      remaining_r <= 2'd0;
    end else begin
      armed_r <= 1'b1;
      case (state_r)
        ISSUE_IDLE: begin
          if (accept_s) begin
            state_r     <= ISSUE_BUSY;
            armed_r     <= 1'b0;
            base_r      <= req_addr;
            meta_r      <= req_meta;
            line_idx_r  <= 2'd0;
            remaining_r <= req_nlines;
          end
        end
        ISSUE_BUSY: begin
          if (issue_s) begin
            if (!eop_s) begin
              line_idx_r  <= line_idx_r + 2'd1;
              remaining_r <= remaining_r - 2'd1;
            end else if (accept_s) begin
              armed_r     <= 1'b0;
              base_r      <= req_addr;
              meta_r      <= req_meta;
              line_idx_r  <= 2'd0;
              remaining_r <= req_nlines;
            end else begin
              state_r <= ISSUE_IDLE;
            end
          end
        end
        default: state_r <= ISSUE_IDLE;
      endcase
    end
  end

  cci_mpf_prim_rob_rd_issue_rsp_reg #(
    .TAG         (TAG),
    .N_DATA_BITS (N_DATA_BITS)
  ) rsp_reg (
    .clk           (clk),
    .reset         (reset),
    .issue         (issue_s),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_tag   (mem_rsp_tag),
    .mem_rsp_data  (mem_rsp_data),
    .rob_data_en   (rob_data_en),
    .rob_data_idx  (rob_data_idx),
    .rob_data      (rob_data),
    .outstanding   (outstanding)
  );

  cci_mpf_prim_rob_rd_issue_chk #(
    .N_ROB_ENTRIES (N_ROB_ENTRIES),
    .MAX_LINES     (MAX_LINES),
    .TAG           (TAG)
  ) chk (
    .clk           (clk),
    .reset         (reset),
    .req_en        (req_en),
    .req_rdy       (req_rdy),
    .req_nlines    (req_nlines),
    .rob_enq_en    (rob_enq_en),
    .mem_req_valid (mem_req_valid),
    .rob_not_full  (rob_not_full),
    .rob_data_en   (rob_data_en),
    .outstanding   (outstanding)
  );

`ifdef CCI_MPF_PRIM_ROB_RD_ISSUE_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lines        <= 32'd0;
      stat_stall_cycles <= 32'd0;
    end else begin
      if (issue_s && (stat_lines != 32'hFFFF_FFFF)) begin
        stat_lines <= stat_lines + 32'd1;
      end
      if ((state_r == ISSUE_BUSY) && !issue_ok_s && (stat_stall_cycles != 32'hFFFF_FFFF)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_rob_rd_issue.sv
// Randomized, model-checked bench for cci_mpf_prim_rob_rd_issue with directed anchors.
module tb_cci_mpf_prim_rob_rd_issue;

  localparam int NE  = 8;
  localparam int TW  = 3;
  localparam int AB  = 42;
  localparam int DB  = 512;
  localparam int MB  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_en = 1'b0;
  logic [AB-1:0] req_addr = '0;
  logic [1:0]    req_nlines = '0;
  logic [MB-1:0] req_meta = '0;
  logic          req_rdy;
  logic          rob_enq_en;
  logic [MB+2:0] rob_enq_meta;
  logic          rob_not_full = 1'b1;
  logic [TW-1:0] rob_enq_idx = '0;
  logic          mem_req_valid;
  logic [AB-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_almost_full = 1'b0;
  logic          mem_rsp_valid = 1'b0;
  logic [TW-1:0] mem_rsp_tag = '0;
  logic [DB-1:0] mem_rsp_data = '0;
  logic          rob_data_en;
  logic [TW-1:0] rob_data_idx;
  logic [DB-1:0] rob_data;
  logic [TW:0]   outstanding;
`ifdef CCI_MPF_PRIM_ROB_RD_ISSUE_STATS_EN
  logic [31:0]   stat_lines;
  logic [31:0]   stat_stall_cycles;
`endif

  cci_mpf_prim_rob_rd_issue #(
    .N_ROB_ENTRIES(NE), .N_ADDR_BITS(AB), .N_DATA_BITS(DB),
    .N_CLIENT_META_BITS(MB), .MAX_LINES(4)
  ) dut (
    .clk(clk), .reset(reset), .req_en(req_en), .req_addr(req_addr),
    .req_nlines(req_nlines), .req_meta(req_meta), .req_rdy(req_rdy),
    .rob_enq_en(rob_enq_en), .rob_enq_meta(rob_enq_meta),
    .rob_not_full(rob_not_full), .rob_enq_idx(rob_enq_idx),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_tag(mem_req_tag), .mem_req_almost_full(mem_req_almost_full),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_data(mem_rsp_data), .rob_data_en(rob_data_en),
    .rob_data_idx(rob_data_idx), .rob_data(rob_data),
`ifdef CCI_MPF_PRIM_ROB_RD_ISSUE_STATS_EN
    .stat_lines(stat_lines), .stat_stall_cycles(stat_stall_cycles),
`endif
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending lines of the current request, ROB slot states, counters.
  typedef struct {
    logic [AB-1:0] addr;
    logic [MB-1:0] meta;
    logic [1:0]    idx;
    logic          eop;
  } line_t;

  line_t         pend[$];
  bit            m_wait = 0;
  int            m_out = 0;
  int            tag_st[NE];   // 0 free, 1 awaiting response, 2 response in flight
  int            alloc = 0;
  int            n_acc = 0;
  int            m_lines = 0;
  bit            started = 0;
  bit            chk_en = 0;
  bit            rnf_want = 1;

  bit            e_rdy, e_issue, e_den;
  line_t         e_line;
  logic [TW-1:0] e_didx;
  logic [DB-1:0] e_data;

  logic          s_rdy, s_enq, s_valid, s_den;
  logic [AB-1:0] s_addr;
  logic [TW-1:0] s_tag, s_didx;
  logic [MB+2:0] s_meta;
  logic [TW:0]   s_out;

  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DB-1:0] rand_data();
    logic [DB-1:0] d;
    for (int k = 0; k < DB/32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  // Cycle-level compare of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_rdy", DB'(req_rdy), DB'(e_rdy));
      chk("rob_enq_en", DB'(rob_enq_en), DB'(e_issue));
      chk("mem_req_valid", DB'(mem_req_valid), DB'(e_issue));
      if (e_issue) begin
        chk("mem_req_addr", DB'(mem_req_addr), DB'(e_line.addr));
        chk("mem_req_tag", DB'(mem_req_tag), DB'(alloc));
        chk("rob_enq_meta", DB'(rob_enq_meta), DB'({e_line.meta, e_line.idx, e_line.eop}));
      end
      chk("rob_data_en", DB'(rob_data_en), DB'(e_den));
      if (e_den) begin
        chk("rob_data_idx", DB'(rob_data_idx), DB'(e_didx));
        chk("rob_data", rob_data, e_data);
      end
      chk("outstanding", DB'(outstanding), DB'(m_out));
    end
  end

  task automatic model_update();
    if (reset) begin
      pend.delete();
      m_wait = 0; m_out = 0; alloc = 0; e_den = 0; m_lines = 0;
      for (int i = 0; i < NE; i++) tag_st[i] = 0;
      started = 1;
    end else begin
      if (e_den) begin
        tag_st[e_didx] = 0;
        m_out--;
      end
      if (e_issue) begin
        tag_st[alloc] = 1;
        alloc = (alloc + 1) % NE;
        void'(pend.pop_front());
        m_out++;
        m_lines++;
      end
      if (mem_rsp_valid) tag_st[mem_rsp_tag] = 2;
      m_wait = 0;
      if (req_en && e_rdy) begin
        for (int i = 0; i <= int'(req_nlines); i++) begin
          line_t l;
          l.addr = req_addr + AB'(i);
          l.meta = req_meta;
          l.idx  = 2'(i);
          l.eop  = (i == int'(req_nlines));
          pend.push_back(l);
        end
        m_wait = 1;
        n_acc++;
      end
      e_den  = mem_rsp_valid;
      e_didx = mem_rsp_tag;
      e_data = mem_rsp_data;
    end
  endtask

  // One clock cycle: finish input drive, derive expectations, sample, advance model
  task automatic cyc();
    bit ok;
    rob_enq_idx  = TW'(alloc);
    rob_not_full = rnf_want && (tag_st[alloc] == 0);
    ok      = rob_not_full && !mem_req_almost_full;
    e_issue = (pend.size() > 0) && !m_wait && ok;
    if (pend.size() > 0) e_line = pend[0];
    e_rdy   = (pend.size() == 0) || (e_issue && pend.size() == 1);
    if (req_en && !e_rdy) req_en = 1'b0;
    chk_en  = started && !reset;
    @(negedge clk);
    s_rdy = req_rdy; s_enq = rob_enq_en; s_valid = mem_req_valid; s_den = rob_data_en;
    s_addr = mem_req_addr; s_tag = mem_req_tag; s_meta = rob_enq_meta;
    s_didx = rob_data_idx; s_out = outstanding;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    req_en = 1'b0; mem_rsp_valid = 1'b0; mem_req_almost_full = 1'b0; rnf_want = 1;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    n_acc = 0;
  endtask

  task automatic set_req(input logic [AB-1:0] a, input logic [1:0] nl, input logic [MB-1:0] m);
    req_en = 1'b1; req_addr = a; req_nlines = nl; req_meta = m;
  endtask

  initial begin
    logic [7:0]    mask;
    logic [MB+2:0] em;
    int            tags[$];
    int            order[$];
    int            cand[$];

    // Reset state
    do_reset();
    cyc();
    chk("rst_rdy", DB'(s_rdy), DB'(1'b1));
    chk("rst_enq", DB'(s_enq), DB'(1'b0));
    chk("rst_den", DB'(s_den), DB'(1'b0));
    chk("rst_out", DB'(s_out), DB'(0));

    // Single-line request
    set_req(42'h100, 2'd0, 8'h5A);
    cyc();
    idle_in();
    cyc();
    chk("s1_bubble_enq", DB'(s_enq), DB'(1'b0));
    cyc();
    chk("s1_enq", DB'(s_enq), DB'(1'b1));
    chk("s1_addr", DB'(s_addr), DB'(42'h100));
    chk("s1_tag", DB'(s_tag), DB'(3'd0));
    chk("s1_meta", DB'(s_meta), DB'(11'h2D1));
    chk("s1_rdy", DB'(s_rdy), DB'(1'b1));
    mem_rsp_valid = 1'b1; mem_rsp_tag = 3'd0; mem_rsp_data = rand_data();
    cyc();
    chk("s1_out1", DB'(s_out), DB'(1));
    idle_in();
    cyc();
    chk("s1_den", DB'(s_den), DB'(1'b1));
    cyc();
    chk("s1_out0", DB'(s_out), DB'(0));

    // Four-line request crossing a 1K boundary
    do_reset();
    set_req(42'h3FF, 2'd3, 8'h77);
    cyc();
    idle_in();
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      em = {8'h77, i[1:0], (i == 3)};
      chk("m4_enq", DB'(s_enq), DB'(1'b1));
      chk("m4_addr", DB'(s_addr), DB'(42'h3FF + 42'(i)));
      chk("m4_tag", DB'(s_tag), DB'(i));
      chk("m4_meta", DB'(s_meta), DB'(em));
      chk("m4_rdy", DB'(s_rdy), DB'(i == 3));
    end

    // Back-to-back two-line requests, request held
    do_reset();
    mask = 8'h00;
    for (int c = 0; c < 8; c++) begin
      if (n_acc < 2) set_req(42'h40, 2'd1, 8'h11);
      else req_en = 1'b0;
      cyc();
      mask[c] = s_enq;
      if (s_enq) tags.push_back(int'(s_tag));
    end
    chk("b2b_pattern", DB'(mask), DB'(8'b0110_1100));
    for (int i = 0; i < 4; i++) chk("b2b_tag", DB'(i < tags.size() ? tags[i] : -1), DB'(i));

    // Backpressure from memory then from ROB
    do_reset();
    set_req(42'h2000, 2'd3, 8'h33);
    cyc();
    idle_in();
    cyc();
    cyc();
    mem_req_almost_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_af_enq", DB'(s_enq), DB'(1'b0));
      chk("bp_af_rdy", DB'(s_rdy), DB'(1'b0));
    end
    mem_req_almost_full = 1'b0;
    cyc();
    chk("bp_af_addr", DB'(s_addr), DB'(42'h2001));
    chk("bp_af_tag", DB'(s_tag), DB'(3'd1));
    rnf_want = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_rnf_valid", DB'(s_valid), DB'(1'b0));
    end
    rnf_want = 1;
    cyc();
    chk("bp_rnf_addr", DB'(s_addr), DB'(42'h2002));
    chk("bp_rnf_tag", DB'(s_tag), DB'(3'd2));

    // Tag wrap with out-of-order responses
    do_reset();
    order = '{0, 7, 3, 1, 2, 4, 5, 6};
    for (int c = 0; c < 30; c++) begin
      if (n_acc < 2) set_req(42'h500, 2'd3, 8'hC3);
      else req_en = 1'b0;
      mem_rsp_valid = 1'b0;
      if (order.size() > 0 && tag_st[order[0]] == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = TW'(order.pop_front());
        mem_rsp_data  = rand_data();
      end
      cyc();
    end
    idle_in();
    chk("wrap_out0", DB'(s_out), DB'(0));
    set_req(42'h900, 2'd0, 8'h01);
    cyc();
    idle_in();
    cyc();
    cyc();
    chk("wrap_tag0", DB'(s_enq ? int'(s_tag) : -1), DB'(0));

    // Reset in the middle of a request
    do_reset();
    set_req(42'h600, 2'd3, 8'h44);
    cyc();
    idle_in();
    cyc(); cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("mr_enq", DB'(s_enq), DB'(1'b0));
    chk("mr_valid", DB'(s_valid), DB'(1'b0));
    chk("mr_den", DB'(s_den), DB'(1'b0));
    chk("mr_out", DB'(s_out), DB'(0));
    chk("mr_rdy", DB'(s_rdy), DB'(1'b1));

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      mem_req_almost_full = ($urandom_range(0, 7) == 0);
      rnf_want = ($urandom_range(0, 7) != 0);
      req_en   = ($urandom_range(0, 2) == 0);
      req_addr = ($urandom_range(0, 3) == 0) ? 42'h3FFFFFFFFFE + 42'($urandom_range(0, 1))
                                             : AB'({$urandom(), $urandom()});
      req_nlines = 2'($urandom_range(0, 3));
      req_meta   = MB'($urandom());
      cand.delete();
      for (int t = 0; t < NE; t++) if (tag_st[t] == 1) cand.push_back(t);
      mem_rsp_valid = 1'b0;
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = TW'(cand[$urandom_range(0, cand.size() - 1)]);
        mem_rsp_data  = rand_data();
      end
      cyc();
    end
    idle_in();
    for (int c = 0; c < 60; c++) begin
      cand.delete();
      for (int t = 0; t < NE; t++) if (tag_st[t] == 1) cand.push_back(t);
      mem_rsp_valid = 1'b0;
      if (cand.size() > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = TW'(cand[0]);
        mem_rsp_data  = rand_data();
      end
      cyc();
    end
    chk("drain_out0", DB'(s_out), DB'(0));
`ifdef CCI_MPF_PRIM_ROB_RD_ISSUE_STATS_EN
    chk("stat_lines", DB'(stat_lines), DB'(m_lines));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
